seq_detect_ctrl: RTL and testbench

- Run controller for serial bit-pattern detection.
- Accepts a start command with a latched configuration: pattern, length, overlap mode, match target and bit window.
- Consumes a valid/ready serial bit stream, detects the programmed pattern, counts matches, and terminates the run on target reached, window exhausted or abort.
- Sits between a host/config interface and the serial input. It generalises the fixed-pattern Mealy detector into a programmable, sequenced resource.

---
 rtl/seq_detect_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern-detection run controller.
// A start latches a shadow configuration; the run then counts matches and ends on target, window or abort.
module seq_detect_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8,
  parameter int WINW   = 16,
  parameter int LENW   = $clog2(MAXLEN) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [MAXLEN-1:0] i_cfg_pattern,
  input  logic [LENW-1:0]   i_cfg_len,
  input  logic              i_cfg_overlap,
  input  logic [CNTW-1:0]   i_cfg_target,
  input  logic [WINW-1:0]   i_cfg_window,
  input  logic              i_bit_in,
  input  logic              i_bit_valid,
  output logic              o_bit_ready,
  output logic              o_match,
  output logic [CNTW-1:0]   o_match_cnt,
  output logic [WINW-1:0]   o_bits_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_hit_target,
  output logic              o_timeout,
  output logic              o_aborted,
  output logic              o_cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [MAXLEN-1:0] r_pattern;
  logic [LENW-1:0]   r_len;
  logic              r_overlap;
  logic [CNTW-1:0]   r_target;
  logic [WINW-1:0]   r_window;
  // The oldest history bit is only ever needed by the compare, so it is never stored.
  logic [MAXLEN-2:0] r_hist;
  logic [LENW-1:0]   r_fill;
  logic              r_match;
  logic [CNTW-1:0]   r_matchCnt;
  logic [WINW-1:0]   r_bitsCnt;
  logic              r_hitTarget;
  logic              r_timeout;
  logic              r_aborted;
  logic              r_cfgErr;

  logic              w_lenBad;
  logic [MAXLEN-1:0] w_histNew;
  logic [MAXLEN-1:0] w_mask;
  logic [LENW-1:0]   w_fillNew;
  logic              w_patHit;
  logic              w_isMatch;
  logic [CNTW-1:0]   w_matchCntNew;
  logic [WINW-1:0]   w_bitsCntNew;
  logic              w_hitTarget;
  logic              w_hitWindow;

  always_comb begin
    w_lenBad      = (i_cfg_len == '0) || (i_cfg_len > LENW'(MAXLEN));
    w_histNew     = {r_hist, i_bit_in};
    w_mask        = ~({MAXLEN{1'b1}} << r_len);
    w_fillNew     = (r_fill >= r_len) ? r_len : r_fill + 1'b1;
    w_patHit      = ((w_histNew ^ r_pattern) & w_mask) == '0;
    w_isMatch     = (w_fillNew == r_len) && w_patHit;
    w_matchCntNew = r_matchCnt;
    if (w_isMatch && (r_matchCnt != {CNTW{1'b1}})) begin
      w_matchCntNew = r_matchCnt + 1'b1;
    end
    w_bitsCntNew  = r_bitsCnt + 1'b1;
    w_hitTarget   = (r_target != '0) && (w_matchCntNew == r_target);
    w_hitWindow   = (r_window != '0) && (w_bitsCntNew == r_window);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pattern   <= '0;
      r_len       <= '0;
      r_overlap   <= 1'b0;
      r_target    <= '0;
      r_window    <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_match     <= 1'b0;
      r_matchCnt  <= '0;
      r_bitsCnt   <= '0;
      r_hitTarget <= 1'b0;
      r_timeout   <= 1'b0;
      r_aborted   <= 1'b0;
      r_cfgErr    <= 1'b0;
    end else begin
      r_match <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_matchCnt  <= '0;
            r_bitsCnt   <= '0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_hitTarget <= 1'b0;
            r_timeout   <= 1'b0;
            r_aborted   <= 1'b0;
            if (w_lenBad) begin
              r_cfgErr <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_cfgErr  <= 1'b0;
              r_pattern <= i_cfg_pattern;
              r_len     <= i_cfg_len;
              r_overlap <= i_cfg_overlap;
              r_target  <= i_cfg_target;
              r_window  <= i_cfg_window;
              r_state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Abort wins over a bit offered in the same cycle.
          if (i_abort) begin
            r_aborted <= 1'b1;
            r_state   <= ST_DONE;
          end else if (i_bit_valid) begin
            r_hist     <= w_histNew[MAXLEN-2:0];
            r_fill     <= (w_isMatch && !r_overlap) ? '0 : w_fillNew;
            r_bitsCnt  <= w_bitsCntNew;
            r_matchCnt <= w_matchCntNew;
            r_match    <= w_isMatch;
            if (w_hitTarget) begin
              r_hitTarget <= 1'b1;
              r_state     <= ST_DONE;
            end else if (w_hitWindow) begin
              r_timeout <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_bit_ready  = (r_state == ST_RUN);
  assign o_busy       = (r_state == ST_RUN);
  assign o_done       = (r_state == ST_DONE);
  assign o_match      = r_match;
  assign o_match_cnt  = r_matchCnt;
  assign o_bits_cnt   = r_bitsCnt;
  assign o_hit_target = r_hitTarget;
  assign o_timeout    = r_timeout;
  assign o_aborted    = r_aborted;
  assign o_cfg_err    = r_cfgErr;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: a fixed vector table, directed corner sequences
// and a random run compared against a bit-stream reference model.
module tb_seq_detect_ctrl;

  localparam int MAXLEN = 8;
  localparam int CNTW   = 8;
  localparam int WINW   = 16;
  localparam int LENW   = 4;

  logic              clk = 1'b0;
  logic              rstN;
  logic              start, abort, bitIn, bitValid, cfgOverlap;
  logic [MAXLEN-1:0] cfgPattern;
  logic [LENW-1:0]   cfgLen;
  logic [CNTW-1:0]   cfgTarget;
  logic [WINW-1:0]   cfgWindow;
  logic              bitReady, match, busy, done, hitTarget, timeout, aborted, cfgErr;
  logic [CNTW-1:0]   matchCnt;
  logic [WINW-1:0]   bitsCnt;

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW), .WINW(WINW)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_abort(abort),
    .i_cfg_pattern(cfgPattern), .i_cfg_len(cfgLen), .i_cfg_overlap(cfgOverlap),
    .i_cfg_target(cfgTarget), .i_cfg_window(cfgWindow),
    .i_bit_in(bitIn), .i_bit_valid(bitValid),
    .o_bit_ready(bitReady), .o_match(match), .o_match_cnt(matchCnt), .o_bits_cnt(bitsCnt),
    .o_busy(busy), .o_done(done), .o_hit_target(hitTarget), .o_timeout(timeout),
    .o_aborted(aborted), .o_cfg_err(cfgErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        match;
    logic [7:0]  matchCnt;
    logic [15:0] bitsCnt;
    logic        busy;
    logic        done;
    logic        hit;
    logic        timeout;
    logic        aborted;
    logic        cfgErr;
  } outVec_t;

  typedef struct {
    logic    start;
    logic    abort;
    logic    valid;
    logic    bitIn;
    outVec_t exp;
  } vector_t;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: run phase plus the accepted bits since the last fill reset.
  int      mPhase;
  bit [7:0] mPat;
  int      mLen;
  bit      mOv;
  int      mTarget, mWindow, mMatchCnt, mBitsCnt;
  bit      mMatch, mHit, mTimeout, mAborted, mCfgErr;
  bit      mStream[$];

  function automatic outVec_t mkOut(input logic rdy, input logic mt, input int mc, input int bc,
                                    input logic bz, input logic dn, input logic ht,
                                    input logic to, input logic ab, input logic er);
    outVec_t o;
    o.ready = rdy; o.match = mt; o.matchCnt = 8'(mc); o.bitsCnt = 16'(bc);
    o.busy = bz; o.done = dn; o.hit = ht; o.timeout = to; o.aborted = ab; o.cfgErr = er;
    return o;
  endfunction

  function automatic outVec_t dutOut();
    return mkOut(bitReady, match, int'(matchCnt), int'(bitsCnt), busy, done,
                 hitTarget, timeout, aborted, cfgErr);
  endfunction

  function automatic outVec_t modelOut();
    return mkOut(mPhase == 1, mMatch, mMatchCnt, mBitsCnt, mPhase == 1, mPhase == 2,
                 mHit, mTimeout, mAborted, mCfgErr);
  endfunction

  task automatic modelReset();
    mPhase = 0; mPat = '0; mLen = 0; mOv = 0; mTarget = 0; mWindow = 0;
    mMatchCnt = 0; mBitsCnt = 0; mMatch = 0; mHit = 0; mTimeout = 0; mAborted = 0; mCfgErr = 0;
    mStream.delete();
  endtask

  task automatic modelStep();
    bit hit;
    mMatch = 0;
    if (mPhase != 1) begin
      if (start) begin
        mMatchCnt = 0; mBitsCnt = 0; mHit = 0; mTimeout = 0; mAborted = 0;
        mStream.delete();
        if (cfgLen == 0 || int'(cfgLen) > MAXLEN) begin
          mCfgErr = 1; mPhase = 2;
        end else begin
          mCfgErr = 0; mPhase = 1;
          mPat = cfgPattern; mLen = int'(cfgLen); mOv = cfgOverlap;
          mTarget = int'(cfgTarget); mWindow = int'(cfgWindow);
        end
      end
    end else if (abort) begin
      mAborted = 1; mPhase = 2;
    end else if (bitValid) begin
      mStream.push_back(bitIn);
      if (mStream.size() > mLen) void'(mStream.pop_front());
      mBitsCnt = (mBitsCnt + 1) % 65536;
      if (mStream.size() == mLen) begin
        hit = 1;
        for (int k = 0; k < mLen; k++)
          if (mStream[k] != mPat[mLen-1-k]) hit = 0;
        if (hit) begin
          mMatch = 1;
          if (mMatchCnt < 255) mMatchCnt++;
          if (!mOv) mStream.delete();
        end
      end
      if (mTarget != 0 && mMatchCnt == mTarget) begin
        mHit = 1; mPhase = 2;
      end else if (mWindow != 0 && mBitsCnt == mWindow) begin
        mTimeout = 1; mPhase = 2;
      end
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic bv, input logic bi);
    start = st; abort = ab; bitValid = bv; bitIn = bi;
    @(posedge clk);
    if (rstN) modelStep();
    #1;
  endtask

  task automatic checkOutput(input string name, input outVec_t exp);
    outVec_t act;
    act = dutOut();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got rdy=%b m=%b mcnt=%0d bits=%0d busy=%b done=%b hit=%b to=%b ab=%b err=%b, expected rdy=%b m=%b mcnt=%0d bits=%0d busy=%b done=%b hit=%b to=%b ab=%b err=%b",
               name, act.ready, act.match, act.matchCnt, act.bitsCnt, act.busy, act.done, act.hit,
               act.timeout, act.aborted, act.cfgErr, exp.ready, exp.match, exp.matchCnt, exp.bitsCnt,
               exp.busy, exp.done, exp.hit, exp.timeout, exp.aborted, exp.cfgErr);
    end
  endtask

  task automatic checkField(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic setCfg(input logic [7:0] pat, input int len, input logic ov, input int tgt, input int win);
    cfgPattern = pat; cfgLen = 4'(len); cfgOverlap = ov; cfgTarget = 8'(tgt); cfgWindow = 16'(win);
  endtask

  // Bits are given MSB-first: bits[n-1] is sent first.
  task automatic runBits(input string name, input logic [15:0] bits, input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, bits[n-1-i]);
      checkOutput(name, modelOut());
      if (toggle) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput(name, modelOut());
      end
    end
  endtask

  vector_t tbl[9];

  initial begin
    tbl[0] = '{1, 0, 0, 0, mkOut(1, 0, 0, 0, 1, 0, 0, 0, 0, 0)};
    tbl[1] = '{0, 0, 1, 1, mkOut(1, 0, 0, 1, 1, 0, 0, 0, 0, 0)};
    tbl[2] = '{0, 0, 1, 0, mkOut(1, 0, 0, 2, 1, 0, 0, 0, 0, 0)};
    tbl[3] = '{0, 0, 1, 1, mkOut(1, 0, 0, 3, 1, 0, 0, 0, 0, 0)};
    tbl[4] = '{0, 0, 1, 0, mkOut(1, 1, 1, 4, 1, 0, 0, 0, 0, 0)};
    tbl[5] = '{0, 0, 1, 1, mkOut(1, 0, 1, 5, 1, 0, 0, 0, 0, 0)};
    tbl[6] = '{0, 0, 1, 0, mkOut(0, 1, 2, 6, 0, 1, 0, 1, 0, 0)};
    tbl[7] = '{0, 0, 1, 1, mkOut(0, 0, 2, 6, 0, 1, 0, 1, 0, 0)};
    tbl[8] = '{0, 0, 0, 0, mkOut(0, 0, 2, 6, 0, 1, 0, 1, 0, 0)};

    start = 0; abort = 0; bitIn = 0; bitValid = 0;
    setCfg(8'h0A, 4, 1, 0, 6);
    rstN = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", mkOut(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rstN = 1;

    // Overlapping 1010 with a 6-bit window.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].start, tbl[i].abort, tbl[i].valid, tbl[i].bitIn);
      checkOutput($sformatf("table%0d", i), tbl[i].exp);
    end

    // Non-overlapping restart from DONE must clear counts.
    setCfg(8'h0A, 4, 0, 0, 6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("restart", mkOut(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    runBits("noOverlap", 16'b101010, 6, 0);
    checkField("noOverlap.matchCnt", int'(matchCnt), 1);
    checkField("noOverlap.timeout", int'(timeout), 1);

    // Target of 2 ends the run after bit 6; bits 7 and 8 are refused.
    setCfg(8'h0A, 4, 1, 2, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runBits("target", 16'b10101011, 8, 0);
    checkField("target.hit", int'(hitTarget), 1);
    checkField("target.bitsCnt", int'(bitsCnt), 6);
    checkField("target.ready", int'(bitReady), 0);

    // Same run with bit_valid toggling.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runBits("toggle", 16'b10101011, 8, 1);
    checkField("toggle.matchCnt", int'(matchCnt), 2);
    checkField("toggle.bitsCnt", int'(bitsCnt), 6);

    // Abort arrives together with the third bit.
    setCfg(8'h0A, 4, 1, 0, 6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runBits("abort", 16'b10, 2, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("abort", modelOut());
    checkField("abort.aborted", int'(aborted), 1);
    checkField("abort.bitsCnt", int'(bitsCnt), 2);
    checkField("abort.matchCnt", int'(matchCnt), 0);

    // Illegal length is rejected in one cycle.
    setCfg(8'h0A, 0, 1, 0, 6);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("lenZero", mkOut(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    runBits("lenZeroBits", 16'b11, 2, 0);
    checkField("lenZero.bitsCnt", int'(bitsCnt), 0);

    // len == 1: every bit equal to pattern[0] matches.
    setCfg(8'h01, 1, 0, 0, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runBits("lenOne", 16'b10110, 5, 0);
    checkField("lenOne.matchCnt", int'(matchCnt), 3);

    // Asynchronous reset in the middle of a run.
    setCfg(8'h0A, 4, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runBits("preReset", 16'b101, 3, 0);
    #2;
    rstN = 0;
    #1;
    checkOutput("midReset", mkOut(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    modelReset();
    @(negedge clk);
    rstN = 1;

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic st;
      st = ($urandom_range(0, 3) == 0);
      if (st || $urandom_range(0, 15) == 0) begin
        setCfg(8'($urandom), int'($urandom_range(0, 9)), 1'($urandom),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 30)));
        if ($urandom_range(0, 1) == 1) cfgLen = 4'($urandom_range(1, 3));
      end
      applyStimulus(st, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
      checkOutput($sformatf("rand%0d", i), modelOut());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
